// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared pipeline definitions for the fetch stage and its helpers.
//   Holds the PC and instruction widths, the fetch FSM state encoding and
//   small arithmetic helpers used by the fetch logic and its counters.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned PC_WIDTH    = 16;
    localparam int unsigned INSTR_WIDTH = 16;
    localparam int unsigned CNT_WIDTH   = 16;

    // FETCH : request outstanding at pc, IF/ID loads as soon as data returns
    // HOLD  : returned word parked in the skid entry while decode is stalled
    // DRAIN : redirect arrived mid-request; wait out the old request
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Modulo-2^PC_WIDTH PC advance; carry out is intentionally dropped.
    function automatic logic [PC_WIDTH-1:0] pc_add(
        input logic [PC_WIDTH-1:0] pc,
        input logic [PC_WIDTH-1:0] step
    );
        return pc + step;
    endfunction

    // Saturating increment for the performance counters.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] value
    );
        return (value == '1) ? value : value + CNT_WIDTH'(1);
    endfunction

endpackage : pipe_pkg

// File: rtl/fetch_skid.sv
// -----------------------------------------------------------------------------
// fetch_skid
//   One-entry {instr, pc} holding register. Catches a word returned by
//   instruction memory while the IF/ID register cannot accept it.
//
//   Ports
//     clk       in   clock, rising edge
//     rst       in   synchronous active-high reset, clears the entry
//     load      in   capture in_instr/in_pc and mark the entry valid
//     drop      in   invalidate the entry (wins over load)
//     in_instr  in   instruction word to capture
//     in_pc     in   PC of that instruction word
//     valid     out  entry holds a word
//     instr     out  held instruction word
//     pc        out  PC of the held word
// -----------------------------------------------------------------------------
module fetch_skid
    import pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   drop,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]    in_pc,
    output logic                   valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (drop) begin
            // Payload is left as-is; only the valid flag matters once dropped.
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= in_instr;
            pc    <= in_pc;
        end
    end

endmodule : fetch_skid

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage: owns the PC, issues requests to instruction
//   memory, fills the IF/ID register and handles decode stalls and taken
//   branch redirects. One instruction per cycle with single-cycle memory.
//
//   Parameters
//     RESET_PC  PC loaded on reset
//     PC_STEP   word-addressed PC increment per fetched instruction
//
//   Ports
//     clk           in   clock, all state updates on the rising edge
//     rst           in   synchronous active-high reset
//     imem_req      out  instruction memory request
//     imem_addr     out  request address (pc, or the abandoned pc in DRAIN)
//     imem_ready    in   imem_rdata valid for the held request
//     imem_rdata    in   instruction word from memory
//     stall         in   hold from decode/hazard logic
//     branch_valid  in   qualifies taken this cycle
//     taken         in   branch resolved taken
//     target        in   branch target address
//     if_valid      out  IF/ID holds a live instruction
//     if_instr      out  IF/ID instruction
//     if_pc         out  PC of if_instr
//     stall_cnt     out  (FETCH_PERF_CNT_EN) saturating count of ld=0 cycles
//     flush_cnt     out  (FETCH_PERF_CNT_EN) saturating count of redirects
//
//   Build option
//     FETCH_PERF_CNT_EN  adds the stall_cnt / flush_cnt counters and ports.
// -----------------------------------------------------------------------------
module fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 16'h0000,
    parameter int unsigned         PC_STEP  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   branch_valid,
    input  logic                   taken,
    input  logic [PC_WIDTH-1:0]    target,
`ifdef FETCH_PERF_CNT_EN
    output logic [CNT_WIDTH-1:0]   stall_cnt,
    output logic [CNT_WIDTH-1:0]   flush_cnt,
`endif
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc
);

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    fetch_state_t           state;
    fetch_state_t           state_d;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc_d;
    logic [PC_WIDTH-1:0]    drain_addr;
    logic [PC_WIDTH-1:0]    drain_addr_d;

    logic                   if_valid_d;
    logic [INSTR_WIDTH-1:0] if_instr_d;
    logic [PC_WIDTH-1:0]    if_pc_d;

    logic                   ld;
    logic                   redirect;

    logic                   skid_load;
    logic                   skid_drop;
    logic                   skid_valid;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [PC_WIDTH-1:0]    skid_pc;

    // -------------------------------------------------------------------------
    // Skid entry
    // -------------------------------------------------------------------------
    fetch_skid u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .drop     (skid_drop),
        .in_instr (imem_rdata),
        .in_pc    (pc),
        .valid    (skid_valid),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        redirect     = branch_valid && taken;
        // IF/ID can accept a word when decode takes the current one or it is empty.
        ld           = !stall || !if_valid;

        state_d      = state;
        pc_d         = pc;
        drain_addr_d = drain_addr;
        if_valid_d   = if_valid;
        if_instr_d   = if_instr;
        if_pc_d      = if_pc;
        skid_load    = 1'b0;
        skid_drop    = redirect;
        imem_req     = 1'b0;
        imem_addr    = pc;

        // Decode consumed IF/ID; it stays empty unless a new word lands below.
        if (ld) begin
            if_valid_d = 1'b0;
        end

        unique case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_d       = target;
                    if_valid_d = 1'b0;
                    if (!imem_ready) begin
                        // Old request is still in flight: remember its address
                        // so imem_addr stays put until memory answers.
                        state_d      = DRAIN;
                        drain_addr_d = pc;
                    end
                end else if (imem_ready) begin
                    if (ld) begin
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc;
                        pc_d       = pc_add(pc, STEP);
                    end else begin
                        // pc is only advanced once the parked word reaches IF/ID.
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_d       = target;
                    if_valid_d = 1'b0;
                    state_d    = FETCH;
                end else if (ld) begin
                    if_valid_d = 1'b1;
                    if_instr_d = skid_instr;
                    if_pc_d    = skid_pc;
                    pc_d       = pc_add(pc, STEP);
                    skid_drop  = 1'b1;
                    state_d    = FETCH;
                end
            end

            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                if (redirect) begin
                    pc_d       = target;
                    if_valid_d = 1'b0;
                    state_d    = FETCH;
                end else if (imem_ready) begin
                    // Returned word belongs to the abandoned path; discard it.
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        // No request while reset is held; an abandoned request is simply dropped.
        if (rst) begin
            imem_req = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drain_addr <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            drain_addr <= drain_addr_d;
            if_valid   <= if_valid_d;
            if_instr   <= if_instr_d;
            if_pc      <= if_pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!ld) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (redirect) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end
`endif

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. The reference model views fetch as
//   an ordered instruction stream: sequential PCs from the last reset or
//   redirect point, each word equal to addr + 16'h1000. Every cycle in which
//   decode accepts IF/ID (if_valid && !stall && no redirect) pops the next
//   expected entry. Directed sequences cover the stream, stall/skid,
//   DRAIN, redirect-with-skid, not-taken branches and PC wrap; a randomized
//   phase follows. Optional counters are checked when FETCH_PERF_CNT_EN is set.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT (RESET_PC = 0)
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic        taken = 1'b0;
    logic [15:0] target = '0;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [15:0] stall_cnt_w;
    logic [15:0] flush_cnt_w;
`endif

    // wrap DUT (RESET_PC = 16'hFFFF) with an always-ready memory
    logic        rst_w = 1'b1;
    logic        req_w;
    logic [15:0] addr_w;
    logic        rdy_w;
    logic [15:0] rdata_w;
    logic        stall_w = 1'b0;
    logic        bv_w = 1'b0;
    logic        tk_w = 1'b0;
    logic [15:0] tg_w = '0;
    logic        ifv_w;
    logic [15:0] ifi_w;
    logic [15:0] ifp_w;

    assign rdy_w   = req_w;
    assign rdata_w = addr_w + 16'h1000;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_valid (branch_valid),
        .taken        (taken),
        .target       (target),
`ifdef FETCH_PERF_CNT_EN
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc)
    );

    fetch_stage #(.RESET_PC(16'hFFFF), .PC_STEP(1)) dut_w (
        .clk          (clk),
        .rst          (rst_w),
        .imem_req     (req_w),
        .imem_addr    (addr_w),
        .imem_ready   (rdy_w),
        .imem_rdata   (rdata_w),
        .stall        (stall_w),
        .branch_valid (bv_w),
        .taken        (tk_w),
        .target       (tg_w),
`ifdef FETCH_PERF_CNT_EN
        .stall_cnt    (stall_cnt_w),
        .flush_cnt    (flush_cnt_w),
`endif
        .if_valid     (ifv_w),
        .if_instr     (ifi_w),
        .if_pc        (ifp_w)
    );

    // ------------------------------------------------------------------------
    // Scoreboard and reference model
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] next_pc = 16'h0000;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_deliv = 0;
    int          stall_model = 0;
    int          flush_model = 0;
    logic        prev_wait = 1'b0;
    logic [15:0] prev_addr = '0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a + 16'h1000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic refill();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc    = next_pc;
            e.instr = mem_word(next_pc);
            exp_q.push_back(e);
            next_pc = next_pc + 16'd1;
        end
    endtask

    task automatic model_restart(input logic [15:0] start);
        exp_q.delete();
        next_pc = start;
        refill();
    endtask

    // One cycle of stimulus, applied at the falling edge.
    // rdy: 0 = memory not ready, 1 = ready whenever requested, else random.
    task automatic drive(input logic r, input logic s, input logic bv, input logic tk,
                         input logic [15:0] tg, input int rdy);
        @(negedge clk);
        rst          = r;
        stall        = s;
        branch_valid = bv;
        taken        = tk;
        target       = tg;
        if (r) model_restart(16'h0000);
        else if (bv && tk) model_restart(tg);
        else refill();
        #1;
        case (rdy)
            0:       imem_ready = 1'b0;
            1:       imem_ready = imem_req;
            default: imem_ready = imem_req && ($urandom_range(0, 9) < 6);
        endcase
        imem_rdata = imem_req ? mem_word(imem_addr) : 16'($urandom);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: samples just before each rising edge
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        #4;
        if (rst === 1'b0) begin
            if (prev_wait && imem_req) chk("addr_stable", imem_addr, prev_addr);
            if (if_valid && !stall && !(branch_valid && taken)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: got delivery pc %0h expected none", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_if_pc", if_pc, e.pc);
                    chk("sb_if_instr", if_instr, e.instr);
                    n_deliv++;
                end
            end
            if (if_valid && stall && stall_model < 65535) stall_model++;
            if (branch_valid && taken && flush_model < 65535) flush_model++;
        end else begin
            stall_model = 0;
            flush_model = 0;
        end
        prev_wait = (rst === 1'b0) && imem_req && !imem_ready && !(branch_valid && taken);
        prev_addr = imem_addr;
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic        r, s, bv, tk;
        logic [15:0] tg;

        // reset
        repeat (3) drive(1, 0, 0, 0, 16'h0, 1);
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_if_valid", if_valid, 1'b0);
        chk("rst_if_instr", if_instr, 16'h0);
        chk("rst_if_pc", if_pc, 16'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 16'h0);
        chk("rst_flush_cnt", flush_cnt, 16'h0);
`endif

        // stream after reset (both DUTs leave reset together)
        drive(0, 0, 0, 0, 16'h0, 1);                       // A
        rst_w = 1'b0;
        #1;
        chk("A_imem_req", imem_req, 1'b1);
        chk("A_imem_addr", imem_addr, 16'h0000);
        chk("A_if_valid", if_valid, 1'b0);
        chk("A_w_addr", addr_w, 16'hFFFF);
        chk("A_w_req", req_w, 1'b1);
        drive(0, 0, 0, 0, 16'h0, 1);                       // B
        chk("B_if_valid", if_valid, 1'b1);
        chk("B_if_pc", if_pc, 16'h0000);
        chk("B_if_instr", if_instr, 16'h1000);
        chk("B_imem_addr", imem_addr, 16'h0001);
        chk("B_w_if_pc", ifp_w, 16'hFFFF);
        chk("B_w_if_instr", ifi_w, 16'h0FFF);
        chk("B_w_addr", addr_w, 16'h0000);
        drive(0, 0, 0, 0, 16'h0, 1);                       // C
        chk("C_if_pc", if_pc, 16'h0001);
        chk("C_w_if_pc", ifp_w, 16'h0000);
        chk("C_w_if_instr", ifi_w, 16'h1000);

        // stall for 3 cycles while IF/ID holds 16'h1002
        drive(0, 1, 0, 0, 16'h0, 1);                       // D
        chk("D_if_instr", if_instr, 16'h1002);
        drive(0, 1, 0, 0, 16'h0, 1);                       // E
        chk("E_imem_req_hold", imem_req, 1'b0);
        chk("E_if_instr", if_instr, 16'h1002);
        chk("E_skid_instr", dut.u_skid.instr, 16'h1003);
        drive(0, 1, 0, 0, 16'h0, 1);                       // F
        chk("F_if_instr", if_instr, 16'h1002);
        drive(0, 0, 0, 0, 16'h0, 1);                       // G
        chk("G_if_valid", if_valid, 1'b1);
        drive(0, 0, 0, 0, 16'h0, 1);                       // H
        chk("H_if_instr", if_instr, 16'h1003);
        chk("H_if_pc", if_pc, 16'h0003);
        chk("H_imem_addr", imem_addr, 16'h0004);

        // redirect on the first wait cycle of a slow request at pc 5
        drive(0, 0, 1, 1, 16'h0040, 0);                    // I
        chk("I_imem_addr", imem_addr, 16'h0005);
        drive(0, 0, 0, 0, 16'h0, 0);                       // J
        chk("J_imem_req", imem_req, 1'b1);
        chk("J_imem_addr", imem_addr, 16'h0005);
        chk("J_if_valid", if_valid, 1'b0);
        drive(0, 0, 0, 0, 16'h0, 0);                       // K
        chk("K_imem_addr", imem_addr, 16'h0005);
        drive(0, 0, 0, 0, 16'h0, 1);                       // L: old word returns
        chk("L_imem_addr", imem_addr, 16'h0005);
        drive(0, 0, 0, 0, 16'h0, 1);                       // M
        chk("M_imem_addr", imem_addr, 16'h0040);
        chk("M_if_valid", if_valid, 1'b0);
        drive(0, 0, 0, 0, 16'h0, 1);                       // N
        chk("N_if_pc", if_pc, 16'h0040);
        chk("N_if_instr", if_instr, 16'h1040);

        // redirect while stalled with a valid skid entry
        drive(0, 1, 0, 0, 16'h0, 1);                       // O: word parked
        drive(0, 1, 1, 1, 16'h0100, 1);                    // P: redirect
        chk("P_skid_valid", dut.u_skid.valid, 1'b1);
        drive(0, 0, 0, 0, 16'h0, 1);                       // Q
        chk("Q_if_valid", if_valid, 1'b0);
        chk("Q_skid_valid", dut.u_skid.valid, 1'b0);
        chk("Q_imem_addr", imem_addr, 16'h0100);
        chk("Q_imem_req", imem_req, 1'b1);
        drive(0, 0, 0, 0, 16'h0, 1);                       // R
        chk("R_if_pc", if_pc, 16'h0100);
        chk("R_if_instr", if_instr, 16'h1100);

        // branch_valid without taken is ignored
        drive(0, 0, 1, 0, 16'h0200, 1);                    // S
        drive(0, 0, 0, 0, 16'h0, 1);                       // T
        chk("T_if_valid", if_valid, 1'b1);
        chk("T_if_pc", if_pc, 16'h0102);
        chk("T_imem_addr", imem_addr, 16'h0103);

        // PC wrap through a redirect near the top of the address space
        drive(0, 0, 1, 1, 16'hFFFE, 1);
        drive(0, 0, 0, 0, 16'h0, 1);
        chk("wrap_addr", imem_addr, 16'hFFFE);
        drive(0, 0, 0, 0, 16'h0, 1);
        drive(0, 0, 0, 0, 16'h0, 1);
        chk("wrap_if_pc_ffff", if_pc, 16'hFFFF);
        chk("wrap_addr_0", imem_addr, 16'h0000);
        drive(0, 0, 0, 0, 16'h0, 1);
        chk("wrap_if_pc_0", if_pc, 16'h0000);
        chk("wrap_if_instr_0", if_instr, 16'h1000);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 9) < 3);
            bv = ($urandom_range(0, 9) < 2);
            tk = 1'($urandom_range(0, 1));
            tg = 16'($urandom);
            drive(r, s, bv, tk, tg, 2);
        end

        // let the last edge land before reading counters
        @(negedge clk);
        #2;
        chk("progress", (n_deliv >= 300), 1'b1);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, 16'(stall_model));
        chk("flush_cnt", flush_cnt, 16'(flush_model));
        chk("w_stall_cnt", stall_cnt_w, 16'h0);
        chk("w_flush_cnt", flush_cnt_w, 16'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, sets the PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 1, sets the word-addressed PC increment per fetched instruction.
REQ-003 Port clk  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  in  1  is the synchronous, active-high reset.
REQ-005 Port imem_req  out  1  is the instruction memory request.
REQ-006 Port imem_addr  out  16  is the instruction memory address, equal to the current PC, or to the abandoned PC while in DRAIN.
REQ-007 Port imem_ready  in  1  marks imem_rdata valid for the held request.
REQ-008 Port imem_rdata  in  16  is the instruction word.
REQ-009 Port stall  in  1  is the hold from decode/hazard logic.
REQ-010 Port branch_valid  in  1  qualifies taken for this cycle.
REQ-011 Port taken  in  1  is the branch-resolved flag from the register-file compare.
REQ-012 Port target  in  16  is the branch target, the adr register value.
REQ-013 Port if_valid  out  1  marks the IF/ID register as holding a live instruction.
REQ-014 Port if_instr  out  16  is the IF/ID instruction.
REQ-015 Port if_pc  out  16  is the PC of if_instr.

Function
REQ-016 The FSM SHALL have states FETCH, HOLD and DRAIN.
REQ-017 imem_addr SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-018 In FETCH: imem_req=1 and imem_addr=pc; the FSM stays in FETCH while imem_ready=0.
REQ-019 IF/ID load enable SHALL be ld = !stall || !if_valid.
REQ-020 In FETCH with imem_ready=1 and ld=1: the next edge loads if_valid=1, if_instr=imem_rdata and if_pc=pc, sets pc=pc+PC_STEP, and stays in FETCH, giving 1 instruction per cycle with single-cycle memory.
REQ-021 In FETCH with imem_ready=1 and ld=0: imem_rdata and pc are captured into the skid entry and the FSM goes to HOLD.
REQ-022 In HOLD: imem_req=0; when ld=1 the skid entry moves into IF/ID, pc advances by PC_STEP, and the FSM goes to FETCH.
REQ-023 Redirect = branch_valid && taken; it SHALL take priority over stall and over imem_ready.
REQ-024 On redirect: pc=target, if_valid=0 (if_instr and if_pc hold their values), and the skid entry is dropped.
REQ-025 A redirect in FETCH with imem_ready=0 SHALL go to DRAIN, keeping imem_req=1 on the old address until imem_ready, discarding that data, then going to FETCH at target.
REQ-026 A redirect in FETCH with imem_ready=1, in HOLD, or in DRAIN SHALL go directly to FETCH, discarding any returned data.
REQ-027 PC arithmetic SHALL be 16-bit modulo: 16'hFFFF plus 1 yields 16'h0000, with no flag.
REQ-028 branch_valid=1 with taken=0 SHALL have no effect.

Reset
REQ-029 While rst=1: pc=RESET_PC, state=FETCH, imem_req=0, if_valid=0, if_instr=0, if_pc=0, skid entry cleared, counters 0.
REQ-030 A reset asserted mid-request or in DRAIN SHALL abandon the request without waiting for imem_ready; imem_req first rises the cycle after rst falls.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN defined: 16-bit saturating output ports stall_cnt, which increments each cycle with ld=0, and flush_cnt, which increments on each redirect, are added.
REQ-032 Without FETCH_PERF_CNT_EN those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Shared package pipe_pkg SHALL hold PC_WIDTH=16, INSTR_WIDTH=16 and the fetch state encoding.
REQ-034 The skid entry SHALL be the sub-module fetch_skid, a 1-entry {instr, pc} holding register with load/drop/valid.

Verification
REQ-035 Stream: after rst, single-cycle memory returning addr+16'h1000 -> if_pc 0,1,2..., if_instr 16'h1000,16'h1001..., if_valid=1 from the 2nd cycle after rst falls.
REQ-036 Stall: stall=1 for 3 cycles while if_instr=16'h1002 -> IF/ID held, HOLD entered with skid=16'h1003, next IF/ID after release=16'h1003 at if_pc 3, no word lost or duplicated.
REQ-037 Redirect in DRAIN: imem_ready delayed 3 cycles at pc 5, redirect target 16'h0040 on the 1st wait cycle -> old word discarded, next imem_addr=16'h0040, if_valid=0 until its return.
REQ-038 Redirect with stall=1 and a valid skid -> if_valid=0 next cycle, skid dropped, imem_addr=target.
REQ-039 Wrap: RESET_PC=16'hFFFF -> if_pc 16'hFFFF then 16'h0000; branch_valid=1 with taken=0 -> no flush; with FETCH_PERF_CNT_EN, flush_cnt equals the redirect count and stall_cnt equals the ld=0 cycle count.
